// File: rtl/ff_pkg.sv
// ff_pkg: shared types for the flip-flop bank.
// Flip-flop kind selector and the common reset value.
package ff_pkg;

    typedef enum logic [1:0] {
        FF_JK,
        FF_SR,
        FF_D,
        FF_T
    } ff_kind_e;

    localparam logic RST_VAL = 1'b0;

endpackage

// File: rtl/ff_cell.sv
// ff_cell: WIDTH independent flip-flops of one kind.
// a/b map to j/k, s/r, d/-, t/- depending on KIND.
module ff_cell
    import ff_pkg::*;
#(
    parameter ff_kind_e KIND  = FF_D,
    parameter int       WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] jk_n;
    logic [WIDTH-1:0] sr_n;
    logic [WIDTH-1:0] t_n;

    // Next state for each kind; s=r=1 holds so SR never goes X.
    always_comb begin
        jk_n = (a & ~q_q) | (~b & q_q);
        sr_n = (a & ~b) | (q_q & ~(~a & b));
        t_n  = q_q ^ a;
        q_d  = a;
        case (KIND)
            FF_JK:   q_d = jk_n;
            FF_SR:   q_d = sr_n;
            FF_T:    q_d = t_n;
            default: q_d = a;
        endcase
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= {WIDTH{RST_VAL}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ff_multi.sv
// ff_multi: parallel bank of JK, SR, D and T flip-flops.
// Define FF_SR_ERR_EN to add the per-bit sr_err pulse output.
module ff_multi
    import ff_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] qjk,
    output logic [WIDTH-1:0] qsr,
    output logic [WIDTH-1:0] qd,
    output logic [WIDTH-1:0] qt
`ifdef FF_SR_ERR_EN
    ,
    output logic [WIDTH-1:0] sr_err
`endif
);

    logic [WIDTH-1:0] unused_b;
    assign unused_b = '0;

    ff_cell #(.KIND(FF_JK), .WIDTH(WIDTH)) u_jk (
        .clk (clk),
        .rst (rst),
        .a   (j),
        .b   (k),
        .q   (qjk)
    );

    ff_cell #(.KIND(FF_SR), .WIDTH(WIDTH)) u_sr (
        .clk (clk),
        .rst (rst),
        .a   (s),
        .b   (r),
        .q   (qsr)
    );

    ff_cell #(.KIND(FF_D), .WIDTH(WIDTH)) u_d (
        .clk (clk),
        .rst (rst),
        .a   (d),
        .b   (unused_b),
        .q   (qd)
    );

    ff_cell #(.KIND(FF_T), .WIDTH(WIDTH)) u_t (
        .clk (clk),
        .rst (rst),
        .a   (t),
        .b   (unused_b),
        .q   (qt)
    );

`ifdef FF_SR_ERR_EN
    logic [WIDTH-1:0] err_q;
    logic [WIDTH-1:0] err_d;

    // One-cycle flag for every bit sampled with s=r=1.
    always_comb begin
        err_d = s & r;
    end

    // Error flag register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= {WIDTH{RST_VAL}};
        end else begin
            err_q <= err_d;
        end
    end

    // Report illegal SR samples while out of reset.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(|(s & r)))
            else $warning("ff_multi: illegal SR input s=%b r=%b", s, r);
        end
    end

    assign sr_err = err_q;
`endif

endmodule

// File: tb/tb_ff_multi.sv
// tb_ff_multi: directed self-checking bench for ff_multi.
// Covers WIDTH=1 and WIDTH=4 instances.
module tb_ff_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       j = 0, k = 0, s = 0, r = 0, d = 0, t = 0;
    logic       qjk, qsr, qd, qt;
    logic [3:0] j4 = '0, k4 = '0, z4 = '0;
    logic [3:0] qjk4, qsr4, qd4, qt4;
`ifdef FF_SR_ERR_EN
    logic       sr_err;
    logic [3:0] sr_err4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ff_multi #(.WIDTH(1)) u_dut (
        .clk (clk), .rst (rst),
        .j (j), .k (k), .s (s), .r (r), .d (d), .t (t),
        .qjk (qjk), .qsr (qsr), .qd (qd), .qt (qt)
`ifdef FF_SR_ERR_EN
        , .sr_err (sr_err)
`endif
    );

    ff_multi #(.WIDTH(4)) u_w4 (
        .clk (clk), .rst (rst),
        .j (j4), .k (k4), .s (z4), .r (z4), .d (z4), .t (z4),
        .qjk (qjk4), .qsr (qsr4), .qd (qd4), .qt (qt4)
`ifdef FF_SR_ERR_EN
        , .sr_err (sr_err4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        {j, k, s, r, d, t} = '0;
        j4 = '0;
        k4 = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        {j, k, s, r, d, t} = 6'b111111;
        #1;
        checks++; if (qjk !== 1'b0) begin errors++; $display("FAIL rst_async_qjk got %b exp 0", qjk); end
        checks++; if (qsr !== 1'b0) begin errors++; $display("FAIL rst_async_qsr got %b exp 0", qsr); end
        checks++; if (qd !== 1'b0) begin errors++; $display("FAIL rst_async_qd got %b exp 0", qd); end
        checks++; if (qt !== 1'b0) begin errors++; $display("FAIL rst_async_qt got %b exp 0", qt); end
        repeat (2) tick();
        checks++; if ({qjk, qsr, qd, qt} !== 4'b0000) begin errors++; $display("FAIL rst_hold got %b exp 0000", {qjk, qsr, qd, qt}); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (qjk !== 1'b1) begin errors++; $display("FAIL rel_qjk got %b exp 1", qjk); end
        checks++; if (qsr !== 1'b0) begin errors++; $display("FAIL rel_qsr got %b exp 0", qsr); end
        checks++; if (qd !== 1'b1) begin errors++; $display("FAIL rel_qd got %b exp 1", qd); end
        checks++; if (qt !== 1'b1) begin errors++; $display("FAIL rel_qt got %b exp 1", qt); end
    endtask

    task automatic test_jk();
        logic [1:0] vin [5] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
        logic       vexp [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            {j, k} = vin[i];
            tick();
            checks++;
            if (qjk !== vexp[i]) begin
                errors++;
                $display("FAIL jk_step%0d got %b exp %b", i, qjk, vexp[i]);
            end
        end
    endtask

    task automatic test_sr();
        logic [1:0] vin [5] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b11};
        logic       vexp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            {s, r} = vin[i];
            tick();
            checks++;
            if (qsr !== vexp[i]) begin
                errors++;
                $display("FAIL sr_step%0d got %b exp %b", i, qsr, vexp[i]);
            end
`ifdef FF_SR_ERR_EN
            checks++;
            if (sr_err !== (vin[i] == 2'b11)) begin
                errors++;
                $display("FAIL sr_err_step%0d got %b exp %b", i, sr_err, vin[i] == 2'b11);
            end
`endif
        end
    endtask

    task automatic test_dt();
        logic vd [3] = '{1'b1, 1'b0, 1'b1};
        logic vt [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        t = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = vd[i];
            tick();
            checks++;
            if (qd !== vd[i]) begin
                errors++;
                $display("FAIL d_step%0d got %b exp %b", i, qd, vd[i]);
            end
            checks++;
            if (qt !== vt[i]) begin
                errors++;
                $display("FAIL t_step%0d got %b exp %b", i, qt, vt[i]);
            end
        end
        t = 1'b0;
        tick();
        checks++; if (qt !== 1'b1) begin errors++; $display("FAIL t_hold got %b exp 1", qt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        t = 1'b1;
        tick();
        checks++; if (qt !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", qt); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (qt !== 1'b0) begin errors++; $display("FAIL mid_async got %b exp 0", qt); end
        tick();
        checks++; if (qt !== 1'b0) begin errors++; $display("FAIL mid_ignore got %b exp 0", qt); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (qt !== 1'b1) begin errors++; $display("FAIL mid_release got %b exp 1", qt); end
    endtask

    task automatic test_width4();
        do_reset();
        j4 = 4'b1010;
        k4 = 4'b0110;
        tick();
        checks++; if (qjk4 !== 4'b1010) begin errors++; $display("FAIL w4_first got %b exp 1010", qjk4); end
        tick();
        checks++; if (qjk4 !== 4'b1000) begin errors++; $display("FAIL w4_second got %b exp 1000", qjk4); end
        checks++; if (qt4 !== 4'b0000) begin errors++; $display("FAIL w4_qt got %b exp 0000", qt4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_jk();
        test_sr();
        test_dt();
        test_mid_reset();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
